// File: rtl/psd_pkg.sv
// Shared types and default widths for the power-spectrum datapath.
// Holds the sample and FFT length defaults, the complex beat layout and the power type.
// Used by fft_power_calc, fft_bin_counter and downstream PSD blocks.
package psd_pkg;

  localparam int SAMPLE_WIDTH = 16;
  localparam int FFT_LEN_LOG2 = 10;
  localparam int OUT_WIDTH    = 2 * SAMPLE_WIDTH;

  // im occupies the upper half so the packed layout matches data = {im, re}.
  typedef struct packed {
    logic signed [SAMPLE_WIDTH-1:0] im;
    logic signed [SAMPLE_WIDTH-1:0] re;
  } cplx_t;

  typedef logic [OUT_WIDTH-1:0] power_t;

endpackage

// File: rtl/fft_bin_counter.sv
// Bin index counter with frame resync and frame-alignment error pulse.
// Latency: bin_idx is the index of the beat being accepted now; frame_error pulses one cycle after it.
// Backpressure: none of its own; it only advances on beats accepted upstream (beat_acc).
// Ports: clk, reset (sync, active-high), beat_acc, last_in -> bin_idx, frame_error.
module fft_bin_counter
  import psd_pkg::*;
#(
  parameter int LEN_LOG2 = FFT_LEN_LOG2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                beat_acc,
  input  logic                last_in,
  output logic [LEN_LOG2-1:0] bin_idx,
  output logic                frame_error
);

  logic [LEN_LOG2-1:0] count_q, count_d;
  logic                err_q, err_d;
  logic                at_end;

  // N-1 is all ones because N is a power of two.
  assign at_end = (count_q == {LEN_LOG2{1'b1}});

  always_comb begin
    count_d = count_q;
    err_d   = 1'b0;
    if (beat_acc) begin
      // An early last or a missing last both restart the count at bin 0.
      err_d = last_in ^ at_end;
      if (last_in || at_end) begin
        count_d = '0;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign bin_idx     = count_q;
  assign frame_error = err_q;

endmodule

// File: rtl/fft_power_calc.sv
// Converts complex FFT bins into exact unsigned power re^2 + im^2, tagged with the bin index.
// Latency: 3 cycles (input register, squares, sum); one beat per clock.
// Backpressure: no FIFO; the whole pipeline stalls together and in_ready = !out_valid || out_ready.
// Ports: clk, reset (sync, active-high); data_in_* AXI-Stream slave {im, re};
//        data_out_* AXI-Stream master (user = bin index); frame_error pulse; frame_count (saturating).
module fft_power_calc #(
  parameter int SAMPLE_WIDTH = psd_pkg::SAMPLE_WIDTH,
  parameter int FFT_LEN_LOG2 = psd_pkg::FFT_LEN_LOG2,
  parameter int OUT_WIDTH    = 2 * SAMPLE_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [2*SAMPLE_WIDTH-1:0] data_in_data,
  input  logic                      data_in_valid,
  input  logic                      data_in_last,
  output logic                      data_in_ready,
  output logic [OUT_WIDTH-1:0]      data_out_data,
  output logic [FFT_LEN_LOG2-1:0]   data_out_user,
  output logic                      data_out_valid,
  output logic                      data_out_last,
  input  logic                      data_out_ready,
  output logic                      frame_error,
  output logic [31:0]               frame_count
);

  localparam int PW = 2 * SAMPLE_WIDTH;

  // S1: operand registers (DSP A/B registers).
  logic signed [SAMPLE_WIDTH-1:0] re1_q, re1_d, im1_q, im1_d;
  logic                           last1_q, last1_d, vld1_q, vld1_d;
  logic [FFT_LEN_LOG2-1:0]        user1_q, user1_d;
  // S2: product registers (DSP M registers).
  logic signed [PW-1:0]           re_sq_q, re_sq_d, im_sq_q, im_sq_d;
  logic                           last2_q, last2_d, vld2_q, vld2_d;
  logic [FFT_LEN_LOG2-1:0]        user2_q, user2_d;
  // S3: sum register (DSP P register), drives data_out directly.
  logic [OUT_WIDTH-1:0]           pwr_q, pwr_d;
  logic                           last3_q, last3_d, vld3_q, vld3_d;
  logic [FFT_LEN_LOG2-1:0]        user3_q, user3_d;
  logic [31:0]                    fc_q, fc_d;

  logic                           en;
  logic                           in_acc;
  logic                           out_acc;
  logic [PW-1:0]                  sum;
  logic [FFT_LEN_LOG2-1:0]        bin_idx;

  assign en            = !vld3_q || data_out_ready;
  assign data_in_ready = en;
  assign in_acc        = data_in_valid && en;
  assign out_acc       = vld3_q && data_out_ready;

  // Both squares are non-negative and together peak at 2^(PW-1), so an
  // unsigned PW-bit sum cannot overflow.
  assign sum = $unsigned(re_sq_q) + $unsigned(im_sq_q);

  fft_bin_counter #(
    .LEN_LOG2 (FFT_LEN_LOG2)
  ) u_bin_counter (
    .clk         (clk),
    .reset       (reset),
    .beat_acc    (in_acc),
    .last_in     (data_in_last),
    .bin_idx     (bin_idx),
    .frame_error (frame_error)
  );

  always_comb begin
    re1_d   = re1_q;
    im1_d   = im1_q;
    last1_d = last1_q;
    user1_d = user1_q;
    vld1_d  = vld1_q;
    re_sq_d = re_sq_q;
    im_sq_d = im_sq_q;
    last2_d = last2_q;
    user2_d = user2_q;
    vld2_d  = vld2_q;
    pwr_d   = pwr_q;
    last3_d = last3_q;
    user3_d = user3_q;
    vld3_d  = vld3_q;
    fc_d    = fc_q;

    // Payload registers load on every enabled cycle; the valid bits carry
    // bubbles through unchanged so empty slots are never collapsed.
    if (en) begin
      re1_d   = data_in_data[SAMPLE_WIDTH-1:0];
      im1_d   = data_in_data[2*SAMPLE_WIDTH-1:SAMPLE_WIDTH];
      last1_d = data_in_last;
      user1_d = bin_idx;
      vld1_d  = data_in_valid;

      re_sq_d = re1_q * re1_q;
      im_sq_d = im1_q * im1_q;
      last2_d = last1_q;
      user2_d = user1_q;
      vld2_d  = vld1_q;

      pwr_d   = OUT_WIDTH'(sum);
      last3_d = last2_q;
      user3_d = user2_q;
      vld3_d  = vld2_q;
    end

    if (out_acc && last3_q && (fc_q != 32'hFFFF_FFFF)) begin
      fc_d = fc_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      re1_q   <= '0;
      im1_q   <= '0;
      last1_q <= 1'b0;
      user1_q <= '0;
      vld1_q  <= 1'b0;
      re_sq_q <= '0;
      im_sq_q <= '0;
      last2_q <= 1'b0;
      user2_q <= '0;
      vld2_q  <= 1'b0;
      pwr_q   <= '0;
      last3_q <= 1'b0;
      user3_q <= '0;
      vld3_q  <= 1'b0;
      fc_q    <= '0;
    end else begin
      re1_q   <= re1_d;
      im1_q   <= im1_d;
      last1_q <= last1_d;
      user1_q <= user1_d;
      vld1_q  <= vld1_d;
      re_sq_q <= re_sq_d;
      im_sq_q <= im_sq_d;
      last2_q <= last2_d;
      user2_q <= user2_d;
      vld2_q  <= vld2_d;
      pwr_q   <= pwr_d;
      last3_q <= last3_d;
      user3_q <= user3_d;
      vld3_q  <= vld3_d;
      fc_q    <= fc_d;
    end
  end

  assign data_out_data  = pwr_q;
  assign data_out_user  = user3_q;
  assign data_out_last  = last3_q;
  assign data_out_valid = vld3_q;
  assign frame_count    = fc_q;

endmodule
